channel_err_inj: RTL and testbench
==================================

CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 SHALL have no parameters; LFSR seed 16'hACE1 and guard length 8 are fixed constants.
REQ-002 clk  input  1  single clock; all logic updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; logic is in reset while rst=0 at a rising clk edge.
REQ-004 sym_i  input  2  encoded symbol from convolutional encoder, {bit1,bit0}.
REQ-005 valid_i  input  1  sym_i is valid this cycle.
REQ-006 err_en_i  input  1  enable random/burst error injection; 0 = transparent.
REQ-007 err_thresh_i  input  8  random error trigger threshold; 0 = never trigger.
REQ-008 burst_len_i  input  4  symbols per error burst; 0 is treated as 1.
REQ-009 force_err_i  input  1  one-shot forced error request, 2-bit flip.
REQ-010 clr_cnt_i  input  1  synchronous clear of both counters.
REQ-011 sym_o  output  2  symbol to Viterbi decoder, sym_i XOR applied flip mask.
REQ-012 valid_o  output  1  sym_o is valid.
REQ-013 err_mask_o  output  2  flip mask applied to the current sym_o.
REQ-014 sym_cnt_o  output  16  count of valid symbols passed.
REQ-015 err_cnt_o  output  16  count of symbols with a nonzero flip mask.

Function
REQ-016 Latency SHALL be exactly 1 cycle: valid_o(t+1)=valid_i(t) and sym_o(t+1)=sym_i(t)^mask(t); no backpressure.
REQ-017 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per cycle with valid_i=1, regardless of err_en_i; decisions use the pre-advance value.
REQ-018 Random trigger SHALL be: lfsr[7:0] < err_thresh_i (unsigned compare).
REQ-019 Mask selection SHALL be: lfsr[9:8]=00 -> 2'b11, otherwise lfsr[9:8].
REQ-020 FSM states SHALL be IDLE, BURST, GUARD; only valid_i=1 cycles advance state or counters.
REQ-021 IDLE: err_en_i=1 and (random trigger or force_err_i) -> flip current symbol; force uses mask 2'b11, random uses REQ-019 mask; then BURST with remaining=eff_len-1 if eff_len>1 (random only), else GUARD.
REQ-022 force_err_i SHALL produce a single-symbol error (no burst); force takes priority over the random trigger in the same cycle.
REQ-023 BURST: each valid symbol flipped with REQ-019 mask, remaining decrements; the last flipped symbol transitions to GUARD.
REQ-024 GUARD: next 8 valid symbols pass unflipped, then IDLE; force_err_i ignored in BURST and GUARD.
REQ-025 err_en_i=0 in any state SHALL give mask 2'b00 that cycle and force IDLE on the next edge.
REQ-026 burst_len_i is sampled only on IDLE->BURST entry; changes mid-burst have no effect.
REQ-027 sym_cnt_o increments per valid_i; err_cnt_o increments per flipped symbol; both saturate at 16'hFFFF.
REQ-028 clr_cnt_i=1 SHALL zero both counters next cycle; clear wins over simultaneous increment.
REQ-029 When valid_i=0: valid_o=0, err_mask_o=2'b00, sym_o=2'b00 next cycle.

Reset
REQ-030 On rst=0: sym_o=0, valid_o=0, err_mask_o=0, sym_cnt_o=0, err_cnt_o=0, state=IDLE, LFSR=16'hACE1, burst counters=0.
REQ-031 Reset asserted mid-burst or mid-guard SHALL abort immediately; the first post-reset symbol is unflipped unless a new trigger fires.

Verification
REQ-032 err_en_i=0, 100 valid symbols of pattern 1,0,0,1 -> sym_o equals sym_i delayed 1 cycle, err_cnt_o=0, sym_cnt_o=100.
REQ-033 err_en_i=1, thresh=0, force_err_i pulse with sym_i=2'b01 -> sym_o=2'b10, err_mask_o=2'b11, err_cnt_o=1; second force 3 symbols later ignored (GUARD).
REQ-034 err_en_i=1, thresh=255, burst_len_i=4 -> 4 consecutive flipped symbols, then exactly 8 clean, repeating; err_cnt_o=4 after 12 symbols.
REQ-035 burst_len_i=0, thresh=255 -> bursts of 1 flipped + 8 clean.
REQ-036 rst=0 for 1 cycle during BURST -> all outputs 0 next cycle, LFSR=16'hACE1, sequence repeats identically to first run.
REQ-037 Preload counters to 16'hFFFF via long run, then clr_cnt_i with valid_i=1 -> both counters 0; no wrap observed before clear.

Source files
------------

// File: rtl/channel_err_inj.sv
// channel_err_inj: channel error injector between a convolutional encoder and a Viterbi decoder.
// Flips bits of 2-bit symbols with random, burst or forced errors.
// Every burst or forced error is followed by a clean guard window.
module channel_err_inj (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sym_i,
    input  logic        valid_i,
    input  logic        err_en_i,
    input  logic [7:0]  err_thresh_i,
    input  logic [3:0]  burst_len_i,
    input  logic        force_err_i,
    input  logic        clr_cnt_i,
    output logic [1:0]  sym_o,
    output logic        valid_o,
    output logic [1:0]  err_mask_o,
    output logic [15:0] sym_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [3:0]  GUARD_LEN = 4'd8;

    typedef enum logic [1:0] {IDLE, BURST, GUARD} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_lfsr;
    logic [3:0]  r_rem, w_rem_nxt;
    logic [3:0]  r_guard, w_guard_nxt;
    logic [1:0]  w_mask, w_rand_mask;
    logic [3:0]  w_eff_len;
    logic        w_trig;

    assign w_trig      = r_lfsr[7:0] < err_thresh_i;
    assign w_rand_mask = (r_lfsr[9:8] == 2'b00) ? 2'b11 : r_lfsr[9:8];
    assign w_eff_len   = (burst_len_i == 4'd0) ? 4'd1 : burst_len_i;

    // Next-state and flip-mask decode; decisions use the pre-advance LFSR value
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_guard_nxt = r_guard;
        w_mask      = 2'b00;
        if (!err_en_i) begin
            w_state_nxt = IDLE;
            w_rem_nxt   = 4'd0;
            w_guard_nxt = 4'd0;
        end else if (valid_i) begin
            case (r_state)
                IDLE: begin
                    if (force_err_i) begin
                        w_mask      = 2'b11;
                        w_state_nxt = GUARD;
                        w_guard_nxt = GUARD_LEN;
                    end else if (w_trig) begin
                        w_mask = w_rand_mask;
                        if (w_eff_len > 4'd1) begin
                            w_state_nxt = BURST;
                            w_rem_nxt   = w_eff_len - 4'd1;
                        end else begin
                            w_state_nxt = GUARD;
                            w_guard_nxt = GUARD_LEN;
                        end
                    end
                end
                BURST: begin
                    w_mask    = w_rand_mask;
                    w_rem_nxt = r_rem - 4'd1;
                    if (r_rem <= 4'd1) begin
                        w_state_nxt = GUARD;
                        w_rem_nxt   = 4'd0;
                        w_guard_nxt = GUARD_LEN;
                    end
                end
                GUARD: begin
                    w_guard_nxt = r_guard - 4'd1;
                    if (r_guard <= 4'd1) begin
                        w_state_nxt = IDLE;
                        w_guard_nxt = 4'd0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state and burst/guard counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_rem   <= 4'd0;
            r_guard <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_guard <= w_guard_nxt;
        end
    end

    // Fibonacci LFSR, taps 16,14,13,11, advancing once per valid symbol
    always_ff @(posedge clk) begin
        if (!rst)
            r_lfsr <= LFSR_SEED;
        else if (valid_i)
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    // Registered output stage, one cycle of latency; idle cycles drive zeros
    always_ff @(posedge clk) begin
        if (!rst) begin
            sym_o      <= 2'b00;
            valid_o    <= 1'b0;
            err_mask_o <= 2'b00;
        end else begin
            valid_o    <= valid_i;
            sym_o      <= valid_i ? (sym_i ^ w_mask) : 2'b00;
            err_mask_o <= valid_i ? w_mask : 2'b00;
        end
    end

    // Saturating symbol and error counters; clear beats increment
    always_ff @(posedge clk) begin
        if (!rst || clr_cnt_i) begin
            sym_cnt_o <= 16'd0;
            err_cnt_o <= 16'd0;
        end else if (valid_i) begin
            if (sym_cnt_o != 16'hFFFF)
                sym_cnt_o <= sym_cnt_o + 16'd1;
            if (w_mask != 2'b00 && err_cnt_o != 16'hFFFF)
                err_cnt_o <= err_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_channel_err_inj.sv
// tb_channel_err_inj: scoreboard bench for channel_err_inj with a behavioural reference model.
module tb_channel_err_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  sym_i = 2'b00;
    logic        valid_i = 1'b0;
    logic        err_en_i = 1'b0;
    logic [7:0]  err_thresh_i = 8'd0;
    logic [3:0]  burst_len_i = 4'd0;
    logic        force_err_i = 1'b0;
    logic        clr_cnt_i = 1'b0;
    logic [1:0]  sym_o;
    logic        valid_o;
    logic [1:0]  err_mask_o;
    logic [15:0] sym_cnt_o;
    logic [15:0] err_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    logic [36:0] sb_q[$];

    logic [15:0] m_lfsr;
    int          m_st;
    int          m_left;
    int          m_guard;
    logic [15:0] m_sc;
    logic [15:0] m_ec;

    channel_err_inj dut (
        .clk(clk), .rst(rst), .sym_i(sym_i), .valid_i(valid_i), .err_en_i(err_en_i),
        .err_thresh_i(err_thresh_i), .burst_len_i(burst_len_i), .force_err_i(force_err_i),
        .clr_cnt_i(clr_cnt_i), .sym_o(sym_o), .valid_o(valid_o), .err_mask_o(err_mask_o),
        .sym_cnt_o(sym_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the falling edge, predict with the model, compare after the rising edge.
    task automatic cycle(input logic r, input logic v, input logic [1:0] s, input logic e,
                         input logic [7:0] th, input logic [3:0] bl, input logic f, input logic c);
        logic [1:0]  mk;
        logic [1:0]  rm;
        int          len;
        logic [36:0] exp_v;
        logic [36:0] act_v;
        @(negedge clk);
        rst = r; valid_i = v; sym_i = s; err_en_i = e;
        err_thresh_i = th; burst_len_i = bl; force_err_i = f; clr_cnt_i = c;
        mk = 2'b00;
        if (!r) begin
            m_lfsr = 16'hACE1; m_st = 0; m_left = 0; m_guard = 0; m_sc = 16'd0; m_ec = 16'd0;
            exp_v = '0;
        end else begin
            rm = (m_lfsr[9:8] == 2'b00) ? 2'b11 : m_lfsr[9:8];
            if (!e) begin
                m_st = 0;
            end else if (v) begin
                if (m_st == 0) begin
                    if (f) begin
                        mk = 2'b11; m_st = 2; m_guard = 8;
                    end else if (m_lfsr[7:0] < th) begin
                        mk = rm;
                        len = (bl == 4'd0) ? 1 : int'(bl);
                        if (len > 1) begin m_st = 1; m_left = len - 1; end
                        else begin m_st = 2; m_guard = 8; end
                    end
                end else if (m_st == 1) begin
                    mk = rm; m_left--;
                    if (m_left == 0) begin m_st = 2; m_guard = 8; end
                end else begin
                    m_guard--;
                    if (m_guard == 0) m_st = 0;
                end
            end
            if (v) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            if (c) begin
                m_sc = 16'd0; m_ec = 16'd0;
            end else if (v) begin
                if (m_sc != 16'hFFFF) m_sc++;
                if (mk != 2'b00 && m_ec != 16'hFFFF) m_ec++;
            end
            exp_v = {v, v ? mk : 2'b00, v ? (s ^ mk) : 2'b00, m_sc, m_ec};
        end
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        act_v = {valid_o, err_mask_o, sym_o, sym_cnt_o, err_cnt_o};
        n_chk++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL scoreboard t=%0t got v=%b m=%b s=%b sc=%h ec=%h want v=%b m=%b s=%b sc=%h ec=%h",
                     $time, act_v[36], act_v[35:34], act_v[33:32], act_v[31:16], act_v[15:0],
                     exp_v[36], exp_v[35:34], exp_v[33:32], exp_v[31:16], exp_v[15:0]);
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 2'b11, 1'b1, 8'd255, 4'd4, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if ({sym_o, valid_o, err_mask_o, sym_cnt_o, err_cnt_o} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0", {sym_o, valid_o, err_mask_o, sym_cnt_o, err_cnt_o});
        end
    endtask

    task automatic test_transparent();
        logic [1:0] pat[4];
        pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b00; pat[3] = 2'b01;
        do_reset();
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 1'b1, pat[i % 4], 1'b0, 8'd255, 4'd4, 1'b1, 1'b0);
        n_chk++;
        if (sym_cnt_o !== 16'd100 || err_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL transparent_counts got sc=%0d ec=%0d want sc=100 ec=0", sym_cnt_o, err_cnt_o);
        end
    endtask

    task automatic test_force();
        do_reset();
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0);
        n_chk++;
        if (sym_o !== 2'b10 || err_mask_o !== 2'b11 || err_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL force_first got s=%b m=%b ec=%0d want s=10 m=11 ec=1", sym_o, err_mask_o, err_cnt_o);
        end
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'd0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'd0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'd0, 4'd0, 1'b1, 1'b0);
        n_chk++;
        if (err_mask_o !== 2'b00 || err_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL force_in_guard got m=%b ec=%0d want m=00 ec=1", err_mask_o, err_cnt_o);
        end
    endtask

    task automatic test_burst();
        int flips = 0;
        do_reset();
        for (int i = 0; i < 36; i++) begin
            cycle(1'b1, 1'b1, 2'(i), 1'b1, 8'd255, (i < 14) ? 4'd4 : 4'd1, 1'b0, 1'b0);
            if (i < 12) begin
                n_chk++;
                if ((err_mask_o != 2'b00) !== (i < 4)) begin
                    n_err++;
                    $display("FAIL burst_pattern sym=%0d got m=%b want flipped=%0d", i, err_mask_o, i < 4);
                end
            end
            if (i == 11) begin
                n_chk++;
                if (err_cnt_o !== 16'd4) begin
                    n_err++;
                    $display("FAIL burst_errcnt got %0d want 4", err_cnt_o);
                end
            end
        end
    endtask

    task automatic test_burst_zero();
        do_reset();
        for (int i = 0; i < 27; i++) begin
            cycle(1'b1, 1'b1, 2'b10, 1'b1, 8'd255, 4'd0, 1'b0, 1'b0);
            if (i < 9) begin
                n_chk++;
                if ((err_mask_o != 2'b00) !== (i == 0)) begin
                    n_err++;
                    $display("FAIL burst0_pattern sym=%0d got m=%b want flipped=%0d", i, err_mask_o, i == 0);
                end
            end
        end
    endtask

    task automatic test_gaps_and_disable();
        do_reset();
        for (int i = 0; i < 40; i++)
            cycle(1'b1, (i % 3) != 1, 2'(i), (i % 17) != 5, 8'd255, 4'd6, i[2], 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [36:0] rec[10];
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 2'(i), 1'b1, 8'd255, 4'd4, 1'b0, 1'b0);
            rec[i] = {valid_o, err_mask_o, sym_o, sym_cnt_o, err_cnt_o};
        end
        do_reset();
        cycle(1'b1, 1'b1, 2'b00, 1'b1, 8'd255, 4'd4, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 8'd255, 4'd4, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 2'b10, 1'b1, 8'd255, 4'd4, 1'b0, 1'b0);
        n_chk++;
        if ({sym_o, valid_o, err_mask_o, sym_cnt_o, err_cnt_o} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_mid_burst got %h want 0", {sym_o, valid_o, err_mask_o, sym_cnt_o, err_cnt_o});
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 2'(i), 1'b1, 8'd255, 4'd4, 1'b0, 1'b0);
            n_chk++;
            if ({valid_o, err_mask_o, sym_o, sym_cnt_o, err_cnt_o} !== rec[i]) begin
                n_err++;
                $display("FAIL reset_repeat sym=%0d got %h want %h", i,
                         {valid_o, err_mask_o, sym_o, sym_cnt_o, err_cnt_o}, rec[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'b1, $urandom_range(3) != 0, 2'($urandom), $urandom_range(15) != 0, 8'd90,
                  4'($urandom), $urandom_range(7) == 0, $urandom_range(63) == 0);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 65540; i++)
            cycle(1'b1, 1'b1, 2'(i), 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
        n_chk++;
        if (sym_cnt_o !== 16'hFFFF) begin
            n_err++;
            $display("FAIL saturate got %h want FFFF", sym_cnt_o);
        end
        cycle(1'b1, 1'b1, 2'b11, 1'b1, 8'd255, 4'd2, 1'b0, 1'b1);
        n_chk++;
        if (sym_cnt_o !== 16'd0 || err_cnt_o !== 16'd0) begin
            n_err++;
            $display("FAIL clear got sc=%h ec=%h want 0 0", sym_cnt_o, err_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_transparent();
        test_force();
        test_burst();
        test_burst_zero();
        test_gaps_and_disable();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
